// File: rtl/scan_loader_pkg.sv
// scan_loader_pkg -- shared types and constants for the scan-chain loader
// and the enforcement-machine top that embeds it.
package scan_loader_pkg;

  // Bits per image byte / per serialised chunk.
  localparam int BYTE_W = 8;

  // Default scan-chain geometry of the enforcement machine.
  localparam int CONF_LEN_DEF = 14;
  localparam int MEM_LEN_DEF  = 64;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    WAIT_BYTE = 3'd2,
    SHIFT     = 3'd3,
    RUN       = 3'd4
  } state_t;

endpackage

// File: rtl/scan_loader_if.sv
// scan_loader_if -- byte stream feeding the scan loader.
// Handshake: a byte moves on a rising clk edge where s_valid and s_ready are
// both high; the source holds s_data stable while s_valid is high and not
// yet accepted, and s_ready never depends combinationally on s_valid.
interface scan_loader_if;
  import scan_loader_pkg::*;

  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/scan_loader.sv
// scan_loader -- loads configuration + program bytes into the enforcement
// machine's scan chain, LSB first, highest address first, then releases the
// machine from reset.
// Optional feature: define SCAN_LOADER_READBACK_EN to add rb_data/rb_valid,
// which return the previous chain contents byte by byte as they shift out.
module scan_loader
  import scan_loader_pkg::*;
#(
  parameter int CONF_LEN = CONF_LEN_DEF,
  parameter int MEM_LEN  = MEM_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  scan_loader_if.slave      s_if,
  output logic              scan_in,
  output logic              scan_en,
  output logic              scan_reset,
  input  logic              scan_out,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
`ifdef SCAN_LOADER_READBACK_EN
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output state_t            o_state
);

  localparam int TOTAL = CONF_LEN + MEM_LEN;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

  state_t            r_state;
  logic [BYTE_W-2:0] r_rest;       // bits still to be shifted after scan_in
  logic [2:0]        r_bit_cnt;    // index of the bit currently on scan_in
  logic [CNT_W-1:0]  r_byte_cnt;   // whole bytes shifted this load
  logic              r_scan_in;
  logic              r_scan_en;
  logic              r_scan_reset;
  logic              r_core_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_s_ready;

  logic              w_xfer;
  logic [CNT_W-1:0]  w_byte_cnt_nxt;

  assign w_xfer         = r_s_ready & s_if.s_valid;
  assign w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);

  assign s_if.s_ready = r_s_ready;
  assign scan_in      = r_scan_in;
  assign scan_en      = r_scan_en;
  assign scan_reset   = r_scan_reset;
  assign core_reset   = r_core_reset;
  assign busy         = r_busy;
  assign done         = r_done;
  assign o_state      = r_state;

  // Load sequencer with inline serialiser; every output is registered and
  // updated together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rest       <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_scan_in    <= 1'b0;
      r_scan_en    <= 1'b0;
      r_scan_reset <= 1'b0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_s_ready    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= CLEAR;
            r_scan_reset <= 1'b1;
            r_busy       <= 1'b1;
            r_byte_cnt   <= '0;
          end
        end
        CLEAR: begin
          r_state      <= WAIT_BYTE;
          r_scan_reset <= 1'b0;
          r_s_ready    <= 1'b1;
          r_byte_cnt   <= '0;
        end
        WAIT_BYTE: begin
          // A stalled source simply leaves us here with the chain frozen.
          if (w_xfer) begin
            r_state   <= SHIFT;
            r_scan_in <= s_if.s_data[0];
            r_rest    <= s_if.s_data[BYTE_W-1:1];
            r_scan_en <= 1'b1;
            r_s_ready <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (r_bit_cnt == 3'd7) begin
            r_scan_en  <= 1'b0;
            r_scan_in  <= 1'b0;
            r_byte_cnt <= w_byte_cnt_nxt;
            if (w_byte_cnt_nxt == TOTAL_C) begin
              r_state      <= RUN;
              r_core_reset <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              r_state   <= WAIT_BYTE;
              r_s_ready <= 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_scan_in <= r_rest[0];
            r_rest    <= {1'b0, r_rest[BYTE_W-2:1]};
          end
        end
        RUN: begin
          // Reload: machine goes back into reset on the same edge the chain
          // control is cleared.
          if (start) begin
            r_state      <= CLEAR;
            r_scan_reset <= 1'b1;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_byte_cnt   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_LOADER_READBACK_EN
  bit [BYTE_W-1:0] r_cap;
  bit [2:0]        r_cap_cnt;
  bit [BYTE_W-1:0] r_rb_data;
  bit              r_rb_valid;
  logic [BYTE_W-1:0] w_cap_nxt;

  // The first bit out of the chain is bit 0 of the oldest byte.
  assign w_cap_nxt = {scan_out, r_cap[BYTE_W-1:1]};
  assign rb_data   = r_rb_data;
  assign rb_valid  = r_rb_valid;

  // Capture the chain tail on every shift cycle; emit a byte after each 8th bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap      <= '0;
      r_cap_cnt  <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (r_scan_en) begin
        r_cap     <= w_cap_nxt;
        r_cap_cnt <= r_cap_cnt + 3'd1;
        if (r_cap_cnt == 3'd7) begin
          r_rb_valid <= 1'b1;
          r_rb_data  <= w_cap_nxt;
        end
      end
    end
  end
`else
  logic w_unused_scan_out;
  assign w_unused_scan_out = scan_out;
`endif

endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 SHALL have parameter CONF_LEN, default 14: number of configuration bytes in the scan chain.
REQ-002 SHALL have parameter MEM_LEN, default 64: number of program-memory bytes in the scan chain.
REQ-003 SHALL have clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have start, input, 1: one-cycle request to (re)load the enforcement machine.
REQ-006 SHALL have s_data, input, 8: next byte of the image, presented in shift order (highest address first).
REQ-007 SHALL have s_valid, input, 1 and s_ready, output, 1: byte handshake; a transfer occurs when both are high on a clk edge.
REQ-008 SHALL have scan_in, output, 1; scan_en, output, 1; scan_reset, output, 1: drive the machine scan chain.
REQ-009 SHALL have scan_out, input, 1: serial data returned by the scan chain.
REQ-010 SHALL have core_reset, output, 1: reset for the enforcement machine.
REQ-011 SHALL have busy, output, 1 and done, output, 1: status flags.

Function
REQ-012 SHALL implement the states IDLE, CLEAR, WAIT_BYTE, SHIFT and RUN.
REQ-013 IDLE: a start pulse SHALL move to CLEAR; all other inputs are ignored.
REQ-014 CLEAR: scan_reset=1 for exactly 1 cycle, then WAIT_BYTE; the byte counter clears to 0.
REQ-015 WAIT_BYTE: s_ready=1; on a transfer, latch s_data into the shift register and go to SHIFT.
REQ-016 SHIFT: scan_en=1 for exactly 8 consecutive cycles; scan_in drives bit 0 first and bit 7 last (LSB first); s_ready=0.
REQ-017 After the 8th bit of a byte, the byte counter SHALL increment. If the count equals CONF_LEN+MEM_LEN, go to RUN; otherwise go to WAIT_BYTE.
REQ-018 Total shift length SHALL be exactly 8*(CONF_LEN+MEM_LEN) scan_en-high cycles per load; scan_en never asserts in any other state.
REQ-019 When scan_en=0, scan_in SHALL be 0.
REQ-020 core_reset SHALL be 1 in every state except RUN, and SHALL fall on the cycle RUN is entered.
REQ-021 done SHALL be 1 only in RUN; busy SHALL be 1 in CLEAR, WAIT_BYTE and SHIFT.
REQ-022 start in RUN SHALL re-enter CLEAR, reasserting core_reset in the same cycle that scan_reset asserts.
REQ-023 start in CLEAR, WAIT_BYTE or SHIFT SHALL be ignored, so a load in progress is never restarted.
REQ-024 s_valid low in WAIT_BYTE SHALL stall indefinitely with scan_en=0; the chain holds its contents.
REQ-025 The byte counter width SHALL be $clog2(CONF_LEN+MEM_LEN+1); the counter does not wrap within a load.

Reset
REQ-026 reset SHALL force IDLE on the next edge from any state, including mid-SHIFT; the partial byte is discarded.
REQ-027 While in reset: s_ready=0, scan_en=0, scan_in=0, scan_reset=0, core_reset=1, busy=0, done=0, byte counter=0.

Configuration
REQ-028 With SCAN_LOADER_READBACK_EN defined, SHALL add outputs rb_data[7:0] and rb_valid, plus a 2-state register capture path.
REQ-029 With the macro defined, each scan_en cycle SHALL shift scan_out into the capture register LSB-first.
REQ-030 With the macro defined, rb_valid SHALL pulse for 1 cycle after every 8th captured bit, carrying the previous chain contents in the same byte order as s_data.
REQ-031 Without the macro, these ports and the capture logic SHALL be absent, with no other behavioural change.

Structure
REQ-032 A shared package scan_loader_pkg SHALL hold the state enum typedef and the byte-width constant (8).
REQ-033 CONF_LEN and MEM_LEN defaults SHALL live in the package shared with the enforcement top.
REQ-034 The block SHALL be a single module with no sub-module; the serialiser is inline.

Verification
REQ-035 reset high 3 cycles -> core_reset=1, scan_en=0, done=0, s_ready=0.
REQ-036 start, then 78 bytes 0x09,0x01,... with s_valid held high -> scan_reset high 1 cycle; exactly 624 scan_en cycles; scan_in of first byte 0x09 = 1,0,0,1,0,0,0,0; core_reset falls as done rises.
REQ-037 s_valid dropped for 5 cycles after byte 10 -> 5 cycles with scan_en=0 and s_ready=1; shifting resumes with byte 11 intact.
REQ-038 reset pulsed during bit 3 of byte 40 -> IDLE next cycle; a fresh start with the full image loads correctly (chain compare passes).
REQ-039 start pulsed mid-load -> ignored; start in RUN -> core_reset=1 and scan_reset=1 on the same cycle, then full reload.
REQ-040 Readback build: load image A, then load image B -> rb_data stream equals image A byte-for-byte, 78 rb_valid pulses.
